// File: rtl/switch_pio_pkg.sv
// Shared constants and helpers for the switch PIO block: register addresses and bus widths.
package switch_pio_pkg;

    localparam int unsigned AVS_ADDR_W = 2;
    localparam int unsigned AVS_DATA_W = 32;

    localparam logic [AVS_ADDR_W-1:0] ADDR_DATA      = 2'd0;
    localparam logic [AVS_ADDR_W-1:0] ADDR_IRQ_MASK  = 2'd1;
    localparam logic [AVS_ADDR_W-1:0] ADDR_EDGE_MODE = 2'd2;
    localparam logic [AVS_ADDR_W-1:0] ADDR_EDGE_CAP  = 2'd3;

    // Ceiling log2; clog2(v) bits are needed to hold values 0..v-1
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 33; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = 32'(i + 1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/switch_pio_edge_ctrl_if.sv
// Avalon-MM slave register port of the switch PIO.
interface switch_pio_edge_ctrl_if;
    import switch_pio_pkg::*;

    logic [AVS_ADDR_W-1:0] address;
    logic                  chipselect;
    logic                  write_n;
    logic [AVS_DATA_W-1:0] writedata;
    logic [AVS_DATA_W-1:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/switch_debounce_bit.sv
// One switch input: 2-FF synchroniser followed by a consecutive-difference debounce counter.
module switch_debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic stable
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            sync_1 <= pin;
            sync_q <= sync_1;
        end
    end

    // Any cycle of agreement restarts the count, so short glitches never reach stable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync_q == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= sync_q;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/switch_pio_edge_ctrl.sv
// Debounced slide-switch PIO with per-bit edge capture and maskable level interrupt.
module switch_pio_edge_ctrl
    import switch_pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    switch_pio_edge_ctrl_if.slave  avs,
    input  logic [WIDTH-1:0]       in_port,
    output logic                   irq
);

    localparam int unsigned CNT_W_MIN = clog2(DEBOUNCE_CYCLES + 1);

    if (CNT_W < CNT_W_MIN) begin : g_bad_cnt_w
        $error("CNT_W too small for DEBOUNCE_CYCLES");
    end

    if (WIDTH < AVS_DATA_W) begin : g_wr_hi
        logic unused_wr_hi;
        assign unused_wr_hi = ^avs.writedata[AVS_DATA_W-1:WIDTH];
    end

    logic [WIDTH-1:0]      stable;
    logic [WIDTH-1:0]      stable_d;
    logic [WIDTH-1:0]      irq_mask;
    logic [WIDTH-1:0]      edge_mode;
    logic [WIDTH-1:0]      edge_capture;
    logic [WIDTH-1:0]      edge_vec;
    logic [WIDTH-1:0]      wr_bits;
    logic [WIDTH-1:0]      cap_clr;
    logic                  wr_en;
    logic [AVS_DATA_W-1:0] rd_mux;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        switch_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .pin     (in_port[i]),
            .stable  (stable[i])
        );
    end

    // Per-bit edge select: mode 0 catches rising, mode 1 catches falling
    always_comb begin
        wr_en    = avs.chipselect & ~avs.write_n;
        wr_bits  = avs.writedata[WIDTH-1:0];
        edge_vec = (edge_mode & stable_d & ~stable) | (~edge_mode & ~stable_d & stable);
        cap_clr  = (wr_en && (avs.address == ADDR_EDGE_CAP)) ? wr_bits : '0;
    end

    always_comb begin
        rd_mux = '0;
        case (avs.address)
            ADDR_DATA:      rd_mux[WIDTH-1:0] = stable;
            ADDR_IRQ_MASK:  rd_mux[WIDTH-1:0] = irq_mask;
            ADDR_EDGE_MODE: rd_mux[WIDTH-1:0] = edge_mode;
            ADDR_EDGE_CAP:  rd_mux[WIDTH-1:0] = edge_capture;
            default:        rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask  <= '0;
            edge_mode <= '0;
        end else if (wr_en) begin
            if (avs.address == ADDR_IRQ_MASK) begin
                irq_mask <= wr_bits;
            end
            if (avs.address == ADDR_EDGE_MODE) begin
                edge_mode <= wr_bits;
            end
        end
    end

    // A new edge in the same cycle as a write-1-clear keeps the flag set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_d     <= '0;
            edge_capture <= '0;
            irq          <= 1'b0;
            avs.readdata <= '0;
        end else begin
            stable_d     <= stable;
            edge_capture <= (edge_capture & ~cap_clr) | edge_vec;
            irq          <= |(edge_capture & irq_mask);
            avs.readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_switch_pio_edge_ctrl.sv
// Directed bench for switch_pio_edge_ctrl with DEBOUNCE_CYCLES=4, WIDTH=10.
module tb_switch_pio_edge_ctrl;

    localparam int unsigned WIDTH = 10;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] in_port;
    logic             irq;

    int n_checks;
    int n_pass;

    switch_pio_edge_ctrl_if avs ();

    switch_pio_edge_ctrl #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .avs     (avs.slave),
        .in_port (in_port),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and land 1 time unit after the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        avs.address    = a;
        avs.writedata  = d;
        avs.chipselect = 1'b1;
        avs.write_n    = 1'b0;
        tick(1);
        avs.chipselect = 1'b0;
        avs.write_n    = 1'b1;
    endtask

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        reset_n        = 1'b0;
        in_port        = '0;
        avs.address    = 2'd0;
        avs.chipselect = 1'b0;
        avs.write_n    = 1'b1;
        avs.writedata  = '0;

        // 1. reset state
        tick(2);
        check_eq("rst_readdata", avs.readdata, 32'h0);
        check_eq("rst_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
        tick(1);
        check_eq("post_rst_data", avs.readdata, 32'h0);
        check_eq("post_rst_irq", 32'(irq), 32'h0);

        // 2. debounce latency and glitch rejection
        in_port = 10'h005;
        tick(6);
        check_eq("deb_not_yet", avs.readdata, 32'h0);
        tick(1);
        check_eq("deb_accepted", avs.readdata, 32'h005);
        in_port = 10'h205;
        tick(3);
        in_port = 10'h005;
        tick(10);
        check_eq("glitch_data", avs.readdata, 32'h005);
        avs.address = 2'd3;
        tick(1);
        check_eq("glitch_cap", avs.readdata, 32'h005);
        bus_write(2'd3, 32'h3FF);
        tick(1);
        check_eq("cap_clear_all", avs.readdata, 32'h0);

        // register width and read-only DATA
        bus_write(2'd1, 32'hFFFF_FFFF);
        avs.address = 2'd1;
        tick(1);
        check_eq("mask_hi_bits", avs.readdata, 32'h3FF);
        bus_write(2'd1, 32'h001);
        bus_write(2'd0, 32'hFFF);
        avs.address = 2'd0;
        tick(1);
        check_eq("data_ro", avs.readdata, 32'h005);

        // 3. rising capture and irq
        in_port = 10'h004;
        tick(10);
        avs.address = 2'd3;
        tick(1);
        check_eq("fall_in_rise_mode", avs.readdata, 32'h0);
        in_port = 10'h005;
        tick(7);
        check_eq("rise_cap_early", avs.readdata, 32'h0);
        check_eq("rise_irq_early", 32'(irq), 32'h0);
        tick(1);
        check_eq("rise_cap", avs.readdata, 32'h001);
        check_eq("rise_irq", 32'(irq), 32'h1);
        bus_write(2'd3, 32'h001);
        check_eq("clr_irq_lag", 32'(irq), 32'h1);
        tick(1);
        check_eq("clr_irq", 32'(irq), 32'h0);
        check_eq("clr_cap", avs.readdata, 32'h0);

        // 4. falling mode, irq gated by mask
        bus_write(2'd1, 32'h000);
        bus_write(2'd2, 32'h002);
        in_port = 10'h007;
        tick(10);
        avs.address = 2'd3;
        tick(1);
        check_eq("rise_in_fall_mode", avs.readdata, 32'h0);
        in_port = 10'h005;
        tick(10);
        check_eq("fall_cap", avs.readdata, 32'h002);
        check_eq("fall_irq_masked", 32'(irq), 32'h0);
        bus_write(2'd1, 32'h002);
        check_eq("mask_irq_lag", 32'(irq), 32'h0);
        tick(1);
        check_eq("mask_irq", 32'(irq), 32'h1);
        bus_write(2'd3, 32'h3FF);
        tick(1);
        check_eq("fall_clr_irq", 32'(irq), 32'h0);

        // edge_mode change alone produces no edge
        bus_write(2'd2, 32'h3FF);
        tick(3);
        bus_write(2'd2, 32'h000);
        avs.address = 2'd3;
        tick(3);
        check_eq("mode_no_edge", avs.readdata, 32'h0);

        // 5. write-1-clear collides with a new edge on bit3
        in_port = 10'h00D;
        tick(6);
        bus_write(2'd3, 32'h008);
        tick(1);
        check_eq("collide_cap", avs.readdata, 32'h008);
        bus_write(2'd1, 32'h008);
        tick(2);
        check_eq("collide_irq", 32'(irq), 32'h1);

        // 6. reset mid-debounce
        avs.address = 2'd0;
        in_port = 10'h3FF;
        tick(5);
        check_eq("pre_rst_data", avs.readdata, 32'h00D);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_data", avs.readdata, 32'h0);
        check_eq("mid_rst_irq", 32'(irq), 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(6);
        check_eq("rerst_not_yet", avs.readdata, 32'h0);
        tick(1);
        check_eq("rerst_data", avs.readdata, 32'h3FF);
        avs.address = 2'd3;
        tick(1);
        check_eq("rerst_cap", avs.readdata, 32'h3FF);
        check_eq("rerst_irq", 32'(irq), 32'h0);
        avs.address = 2'd1;
        tick(1);
        check_eq("rerst_mask", avs.readdata, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
